fm_operand_classify: RTL and testbench
======================================

// Module: fm_operand_classify
// PURPOSE
//  Pipelined input stage of the FP multiplier that sits directly upstream of fm_special.
//  Registers both operands and classifies each one as zero, infinity, NaN, signalling NaN
//  or denormal. Produces the zero/aisnan/bisnan/infinity flags that fm_special consumes.
//  A valid/ready handshake with a 2-entry skid buffer gives full throughput under backpressure.
// PARAMETERS
//  WIDTH   32  total operand width (sign + exponent + significand)
//  WEXP    8   exponent field width
//  WSIG    23  stored significand width; WIDTH == 1+WEXP+WSIG
//  FTZ     1   1: denormal operands are flagged as zero (flush-to-zero); 0: denormal only
//  CNTW    16  width of the saturating NaN-event counter
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-high reset
//  in_valid    in   1      a/b valid this cycle
//  in_ready    out  1      stage can accept a/b (registered)
//  a, b        in   WIDTH  IEEE-754 operands
//  out_valid   out  1      outputs below hold a classified pair
//  out_ready   in   1      downstream (fm_special / exponent path) accepts the pair
//  a_q, b_q    out  WIDTH  registered operands
//  zero        out  1      a or b is zero (or denormal when FTZ=1)
//  infinity    out  1      a or b is infinity
//  aisnan      out  1      a is NaN (exp all ones, sig != 0)
//  bisnan      out  1      b is NaN
//  snan        out  1      a or b is a signalling NaN (sig MSB == 0)
//  adenorm     out  1      a is denormal (exp == 0, sig != 0)
//  bdenorm     out  1      b is denormal
//  nan_count   out  CNTW   saturating count of accepted pairs with aisnan|bisnan
// BEHAVIOUR
//  - Reset: in_ready=1, out_valid=0, all flags=0, a_q=b_q=0, nan_count=0, skid empty.
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - Latency 1 clk: a pair accepted at edge N appears on the outputs after edge N, with
//    out_valid=1. Throughput 1 pair/clk while out_ready=1.
//  - Storage: main register (drives outputs) plus one skid register; states are
//    EMPTY, ONE (main only) and FULL (main+skid).
//    EMPTY: accept -> ONE.
//    ONE: accept&drain -> ONE (main reloaded); accept&~drain -> FULL; drain&~accept -> EMPTY.
//    FULL: drain -> ONE (skid moves to main). No accept is possible because in_ready=0.
//  - in_ready is registered and equals (next state != FULL). It deasserts on the edge that
//    fills the skid entry, so it never combinationally depends on out_ready.
//  - Outputs are held stable while out_valid & ~out_ready (no change until the transfer).
//  - Classification is computed before the register. The skid stores raw operands plus
//    precomputed flags, so the main-register path has one classifier only.
//  - Flag rules: zero/infinity are the OR of both operands. A signed zero counts as zero.
//    NaN takes precedence: an operand never sets both NaN and infinity.
//  - The zero&infinity combination is passed through unmodified; fm_special flags it invalid.
//  - nan_count increments by 1 per input transfer with a NaN operand and sticks at
//    2^CNTW-1. Reset clears it.
//  - Reset asserted mid-operation discards both entries immediately (asynchronous).
//    out_valid drops in the same cycle.
// STRUCTURE
//  - Shared constants package (fm_constants.v): WIDTH/WEXP/WSIG defaults, exponent
//    all-ones/all-zeros constants, field-slice macros.
//  - One sub-module, fm_classify: combinational, single operand in, outputs
//    {iszero, isinf, isnan, issnan, isdenorm}. It is instantiated twice, for a and b.
//  - Top level holds the handshake FSM, the main and skid registers, and nan_count.
// TESTING
//  1. Reset, then a=0x3F800000, b=0x40000000, out_ready=1 -> 1 clk later out_valid=1,
//     all flags 0, a_q/b_q match the inputs.
//  2. a=0x7F800000, b=0x00000000 -> infinity=1, zero=1, aisnan=bisnan=0.
//  3. a=0x7FC00001, b=0x7F800001 -> aisnan=1, bisnan=1, snan=1; nan_count increments by 1.
//  4. a=0x00000001, FTZ=1 -> adenorm=1, zero=1. With FTZ=0 -> adenorm=1, zero=0.
//  5. Streaming with out_ready=0 for 3 clks -> 2 pairs held, in_ready=0 after the 2nd
//     accept. On release, pairs emerge in order, with no loss and no duplication.
//  6. Reset pulse while FULL -> out_valid=0 and in_ready=1 immediately, nan_count=0.

Source files
------------

// File: rtl/fm_operand_classify_pkg.sv
// Shared types for the FP multiplier operand-classification stage: per-operand class,
// per-pair flag bundle, handshake state encoding and default field widths.
package fm_operand_classify_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int WEXP_DEF  = 8;
  localparam int WSIG_DEF  = 23;
  localparam int CNTW_DEF  = 16;

  typedef struct packed {
    logic iszero;
    logic isinf;
    logic isnan;
    logic issnan;
    logic isdenorm;
  } op_class_t;

  typedef struct packed {
    logic zero;
    logic infinity;
    logic aisnan;
    logic bisnan;
    logic snan;
    logic adenorm;
    logic bdenorm;
  } pair_flags_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  // zero/infinity/snan are pair-level ORs; NaN and denormal stay per operand.
  function automatic pair_flags_t combine_flags(input op_class_t ca, input op_class_t cb);
    pair_flags_t f;
    f.zero     = ca.iszero | cb.iszero;
    f.infinity = ca.isinf | cb.isinf;
    f.aisnan   = ca.isnan;
    f.bisnan   = cb.isnan;
    f.snan     = ca.issnan | cb.issnan;
    f.adenorm  = ca.isdenorm;
    f.bdenorm  = cb.isdenorm;
    return f;
  endfunction

endpackage

// File: rtl/fm_operand_classify_classify.sv
// Combinational IEEE-754 classifier for one operand magnitude (sign never affects the
// class, so only exponent and significand are presented).
module fm_operand_classify_classify
  import fm_operand_classify_pkg::*;
#(
  parameter int WEXP = WEXP_DEF,
  parameter int WSIG = WSIG_DEF,
  parameter int FTZ  = 1
) (
  input  logic [WEXP+WSIG-1:0] mag,
  output op_class_t            cls
);

  logic [WEXP-1:0] exp_f;
  logic [WSIG-1:0] sig_f;
  logic            exp_ones;
  logic            exp_zero;
  logic            sig_nz;

  assign exp_f = mag[WEXP+WSIG-1:WSIG];
  assign sig_f = mag[WSIG-1:0];

  always_comb begin
    exp_ones     = &exp_f;
    exp_zero     = ~|exp_f;
    sig_nz       = |sig_f;
    // NaN wins over infinity: the two are mutually exclusive by the sig_nz split.
    cls.isnan    = exp_ones & sig_nz;
    cls.isinf    = exp_ones & ~sig_nz;
    cls.issnan   = exp_ones & sig_nz & ~sig_f[WSIG-1];
    cls.isdenorm = exp_zero & sig_nz;
    cls.iszero   = exp_zero & (~sig_nz | (FTZ != 0));
  end

endmodule

// File: rtl/fm_operand_classify.sv
// Registered operand/classification stage with valid/ready and a 2-entry skid buffer,
// feeding fm_special; also keeps a saturating count of accepted NaN pairs.
module fm_operand_classify
  import fm_operand_classify_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int WEXP  = WEXP_DEF,
  parameter int WSIG  = WSIG_DEF,
  parameter int FTZ   = 1,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic             zero,
  output logic             infinity,
  output logic             aisnan,
  output logic             bisnan,
  output logic             snan,
  output logic             adenorm,
  output logic             bdenorm,
  output logic [CNTW-1:0]  nan_count
);

  op_class_t   cls_a;
  op_class_t   cls_b;
  pair_flags_t in_flags;

  fm_operand_classify_classify #(.WEXP(WEXP), .WSIG(WSIG), .FTZ(FTZ)) u_class_a (
    .mag (a[WIDTH-2:0]),
    .cls (cls_a)
  );

  fm_operand_classify_classify #(.WEXP(WEXP), .WSIG(WSIG), .FTZ(FTZ)) u_class_b (
    .mag (b[WIDTH-2:0]),
    .cls (cls_b)
  );

  assign in_flags = combine_flags(cls_a, cls_b);

  skid_state_t      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] main_a_q, main_a_d, main_b_q, main_b_d;
  logic [WIDTH-1:0] skid_a_q, skid_a_d, skid_b_q, skid_b_d;
  pair_flags_t      main_flags_q, main_flags_d, skid_flags_q, skid_flags_d;
  logic [CNTW-1:0]  nan_count_q, nan_count_d;
  logic             accept;
  logic             drain;

  assign accept    = in_valid & in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    main_a_d     = main_a_q;
    main_b_d     = main_b_q;
    main_flags_d = main_flags_q;
    skid_a_d     = skid_a_q;
    skid_b_d     = skid_b_q;
    skid_flags_d = skid_flags_q;
    nan_count_d  = nan_count_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_ONE;
          main_a_d     = a;
          main_b_d     = b;
          main_flags_d = in_flags;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_a_d     = a;
          main_b_d     = b;
          main_flags_d = in_flags;
        end else if (accept) begin
          state_d      = ST_FULL;
          skid_a_d     = a;
          skid_b_d     = b;
          skid_flags_d = in_flags;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          state_d      = ST_ONE;
          main_a_d     = skid_a_q;
          main_b_d     = skid_b_q;
          main_flags_d = skid_flags_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Registered ready looks at the next state, so it never depends on out_ready combinationally.
    in_ready_d = (state_d != ST_FULL);
    if (accept && (in_flags.aisnan || in_flags.bisnan) && (nan_count_q != {CNTW{1'b1}}))
      nan_count_d = nan_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      in_ready_q   <= 1'b1;
      main_a_q     <= '0;
      main_b_q     <= '0;
      main_flags_q <= '0;
      skid_a_q     <= '0;
      skid_b_q     <= '0;
      skid_flags_q <= '0;
      nan_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      main_a_q     <= main_a_d;
      main_b_q     <= main_b_d;
      main_flags_q <= main_flags_d;
      skid_a_q     <= skid_a_d;
      skid_b_q     <= skid_b_d;
      skid_flags_q <= skid_flags_d;
      nan_count_q  <= nan_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign a_q       = main_a_q;
  assign b_q       = main_b_q;
  assign zero      = main_flags_q.zero;
  assign infinity  = main_flags_q.infinity;
  assign aisnan    = main_flags_q.aisnan;
  assign bisnan    = main_flags_q.bisnan;
  assign snan      = main_flags_q.snan;
  assign adenorm   = main_flags_q.adenorm;
  assign bdenorm   = main_flags_q.bdenorm;
  assign nan_count = nan_count_q;

endmodule

// File: tb/tb_fm_operand_classify.sv
// Scoreboard bench: two instances (FTZ=1/16-bit counter, FTZ=0/2-bit counter) share the
// same stimulus; expected pairs are queued on accept and popped by per-instance monitors.
module tb_fm_operand_classify;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        in_ready0, out_valid0, zero0, inf0, aisnan0, bisnan0, snan0, adenorm0, bdenorm0;
  logic [31:0] a_q0, b_q0;
  logic [15:0] nan_count0;
  logic        in_ready1, out_valid1, zero1, inf1, aisnan1, bisnan1, snan1, adenorm1, bdenorm1;
  logic [31:0] a_q1, b_q1;
  logic [1:0]  nan_count1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] ea;
    logic [31:0] eb;
    logic [6:0]  ef;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Hand-computed vectors; flags are {zero,infinity,aisnan,bisnan,snan,adenorm,bdenorm}.
  logic [31:0] va  [8] = '{32'h3F800000, 32'h7F800000, 32'h7FC00001, 32'h00000001,
                           32'h80000000, 32'h3F800000, 32'hFF800000, 32'h7F800001};
  logic [31:0] vb  [8] = '{32'h40000000, 32'h00000000, 32'h7F800001, 32'h3F800000,
                           32'h7FC00000, 32'h80400000, 32'h7FFFFFFF, 32'h00000000};
  logic [6:0]  vf1 [8] = '{7'b0000000, 7'b1100000, 7'b0011100, 7'b1000010,
                           7'b1001000, 7'b1000001, 7'b0101000, 7'b1010100};
  logic [6:0]  vf0 [8] = '{7'b0000000, 7'b1100000, 7'b0011100, 7'b0000010,
                           7'b1001000, 7'b0000001, 7'b0101000, 7'b1010100};

  fm_operand_classify #(.WIDTH(32), .WEXP(8), .WSIG(23), .FTZ(1), .CNTW(16)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b),
    .out_valid(out_valid0), .out_ready(out_ready), .a_q(a_q0), .b_q(b_q0),
    .zero(zero0), .infinity(inf0), .aisnan(aisnan0), .bisnan(bisnan0), .snan(snan0),
    .adenorm(adenorm0), .bdenorm(bdenorm0), .nan_count(nan_count0)
  );

  fm_operand_classify #(.WIDTH(32), .WEXP(8), .WSIG(23), .FTZ(0), .CNTW(2)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
    .out_valid(out_valid1), .out_ready(out_ready), .a_q(a_q1), .b_q(b_q1),
    .zero(zero1), .infinity(inf1), .aisnan(aisnan1), .bisnan(bisnan1), .snan(snan1),
    .adenorm(adenorm1), .bdenorm(bdenorm1), .nan_count(nan_count1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitors: one line per output transfer.
  always @(negedge clk) begin
    if (!reset && out_valid0 && out_ready) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0_unexpected_out: got a=0x%08h b=0x%08h want none", a_q0, b_q0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        $display("dut0 out a=%08h b=%08h flags=%07b", a_q0, b_q0,
                 {zero0, inf0, aisnan0, bisnan0, snan0, adenorm0, bdenorm0});
        chk("dut0_a_q", 64'(a_q0), 64'(e.ea));
        chk("dut0_b_q", 64'(b_q0), 64'(e.eb));
        chk("dut0_flags", 64'({zero0, inf0, aisnan0, bisnan0, snan0, adenorm0, bdenorm0}), 64'(e.ef));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid1 && out_ready) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_unexpected_out: got a=0x%08h b=0x%08h want none", a_q1, b_q1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        $display("dut1 out a=%08h b=%08h flags=%07b", a_q1, b_q1,
                 {zero1, inf1, aisnan1, bisnan1, snan1, adenorm1, bdenorm1});
        chk("dut1_a_q", 64'(a_q1), 64'(e.ea));
        chk("dut1_b_q", 64'(b_q1), 64'(e.eb));
        chk("dut1_flags", 64'({zero1, inf1, aisnan1, bisnan1, snan1, adenorm1, bdenorm1}), 64'(e.ef));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int idx);
    int   waited;
    logic done;
    exp_t e0, e1;
    waited = 0;
    done = 1'b0;
    a = va[idx];
    b = vb[idx];
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready0) begin
        e0.ea = va[idx]; e0.eb = vb[idx]; e0.ef = vf1[idx];
        e1.ea = va[idx]; e1.eb = vb[idx]; e1.ef = vf0[idx];
        q0.push_back(e0);
        q1.push_back(e1);
        $display("in  a=%08h b=%08h", va[idx], vb[idx]);
        done = 1'b1;
      end else if (++waited > 50) begin
        total++; bad++;
        $display("FAIL send_timeout: got in_ready=0 for 50 clks want 1");
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(3);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready0), 64'd1);
    chk("rst_out_valid", 64'(out_valid0), 64'd0);
    chk("rst_a_q", 64'(a_q0), 64'd0);
    chk("rst_flags", 64'({zero0, inf0, aisnan0, bisnan0, snan0, adenorm0, bdenorm0}), 64'd0);
    chk("rst_nan_count", 64'(nan_count0), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    // Streaming all vectors at full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(i);
    idle(3);
    @(negedge clk);
    chk("nan_count_4", 64'(nan_count0), 64'd4);
    chk("nan_count_sat", 64'(nan_count1), 64'd3);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("idle_out_valid", 64'(out_valid0), 64'd0);
    @(posedge clk); #1;

    // Backpressure: two pairs held, skid fills
    out_ready = 1'b0;
    send(0);
    send(1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready0), 64'd0);
      chk("bp_out_valid", 64'(out_valid0), 64'd1);
      chk("bp_a_hold", 64'(a_q0), 64'(va[0]));
      chk("bp_b_hold", 64'(b_q0), 64'(vb[0]));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(4);
    @(negedge clk);
    chk("bp_q0_drained", 64'(q0.size()), 64'd0);
    chk("bp_q1_drained", 64'(q1.size()), 64'd0);
    chk("bp_in_ready_back", 64'(in_ready0), 64'd1);
    @(posedge clk); #1;

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    send(2);
    send(3);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready0), 64'd0);
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid0), 64'd0);
    chk("arst_in_ready", 64'(in_ready0), 64'd1);
    chk("arst_nan_count", 64'(nan_count0), 64'd0);
    chk("arst_nan_count1", 64'(nan_count1), 64'd0);
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    send(0);
    idle(3);
    @(negedge clk);
    chk("post_rst_q0", 64'(q0.size()), 64'd0);
    chk("post_rst_nan_count", 64'(nan_count0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
